// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, ROM request, in-order fetch queue and decode handshake.
// Optional: `define MISALIGN_TRAP_EN to trap misaligned redirect targets into HALT.
module instr_fetch_unit #(
  parameter int          TAM_POSICIONES = 1024,
  parameter int          TAM_PALABRA    = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          QDEPTH         = 2
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  output logic                              CE,
  output logic                              READ_EN,
  output logic [$clog2(TAM_POSICIONES)-1:0] INS_ADDRESS,
  input  logic [TAM_PALABRA-1:0]            INSTRUCTION,
  output logic                              IF_VALID,
  output logic [TAM_PALABRA-1:0]            IF_INSTR,
  output logic [31:0]                       IF_PC,
  input  logic                              ID_READY,
  input  logic                              REDIRECT,
  input  logic [31:0]                       REDIRECT_PC,
  output logic                              IF_MISALIGN
);

  localparam int AW = $clog2(TAM_POSICIONES);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [31:0]            pc_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic [31:0]            q_pc_r    [QDEPTH];
  logic [TAM_PALABRA-1:0] q_instr_r [QDEPTH];
  logic                   misalign_r;

  logic                   full_s;
  logic                   pop_s;
  logic                   fetch_ok_s;
  logic                   misalign_s;
  logic [31:0]            redirect_pc_s;

`ifdef MISALIGN_TRAP_EN
  assign misalign_s    = |REDIRECT_PC[1:0];
  assign redirect_pc_s = REDIRECT_PC;
  assign IF_MISALIGN   = misalign_r;
`else
  // Low address bits are simply dropped, so the trap path never fires.
  assign misalign_s    = 1'b0;
  assign redirect_pc_s = REDIRECT_PC & 32'hFFFF_FFFC;
  assign IF_MISALIGN   = 1'b0;
`endif

  assign full_s      = (count_r == Q_FULL);
  assign IF_VALID    = (count_r != {CW{1'b0}});
  assign pop_s       = IF_VALID && ID_READY;
  assign fetch_ok_s  = (state_r == RUN) && !REDIRECT && (!full_s || pop_s);
  assign INS_ADDRESS = pc_r[AW+1:2];
  assign IF_PC       = IF_VALID ? q_pc_r[rd_ptr_r]    : 32'h0000_0000;
  assign IF_INSTR    = IF_VALID ? q_instr_r[rd_ptr_r] : {TAM_PALABRA{1'b0}};

  // Next-state and ROM strobe decode; a redirect overrides the normal transitions.
  always_comb begin
    state_nxt_s = state_r;
    CE          = 1'b0;
    READ_EN     = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        CE      = 1'b1;
        READ_EN = fetch_ok_s;
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (REDIRECT) begin
      state_nxt_s = misalign_s ? HALT : RUN;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, queue pointers/occupancy and trap flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_r       <= RESET_PC;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      misalign_r <= 1'b0;
    end else if (REDIRECT) begin
      // Flush wins over any pop presented in the same cycle.
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      misalign_r <= misalign_s;
      if (!misalign_s) begin
        pc_r <= redirect_pc_s;
      end else begin
        pc_r <= pc_r;
      end
    end else begin
      if (fetch_ok_s) begin
        pc_r     <= pc_r + 32'd4;
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        pc_r     <= pc_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({fetch_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage: capture the combinational ROM word alongside its PC.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_r[i]    <= 32'h0000_0000;
        q_instr_r[i] <= {TAM_PALABRA{1'b0}};
      end
    end else if (fetch_ok_s) begin
      q_pc_r[wr_ptr_r]    <= pc_r;
      q_instr_r[wr_ptr_r] <= INSTRUCTION;
    end else begin
      q_pc_r[wr_ptr_r]    <= q_pc_r[wr_ptr_r];
      q_instr_r[wr_ptr_r] <= q_instr_r[wr_ptr_r];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: ROM word n holds 32'h1000_0000 + n.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        READ_EN;
  logic [9:0]  INS_ADDRESS;
  logic [31:0] INSTRUCTION;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic        ID_READY;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IF_MISALIGN;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(
    .TAM_POSICIONES(1024),
    .TAM_PALABRA   (32),
    .RESET_PC      (32'h0000_0000),
    .QDEPTH        (2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CE         (CE),
    .READ_EN    (READ_EN),
    .INS_ADDRESS(INS_ADDRESS),
    .INSTRUCTION(INSTRUCTION),
    .IF_VALID   (IF_VALID),
    .IF_INSTR   (IF_INSTR),
    .IF_PC      (IF_PC),
    .ID_READY   (ID_READY),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .IF_MISALIGN(IF_MISALIGN)
  );

  always #5 CLK = ~CLK;

  assign INSTRUCTION = 32'h1000_0000 + {22'd0, INS_ADDRESS};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; ID_READY = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
    tick(); tick();
    check("rst_valid", {31'd0, IF_VALID}, 32'd0);
    check("rst_pc", IF_PC, 32'h0);
    check("rst_instr", IF_INSTR, 32'h0);
    check("rst_ce", {31'd0, CE}, 32'd0);
    check("rst_rden", {31'd0, READ_EN}, 32'd0);
    check("rst_misalign", {31'd0, IF_MISALIGN}, 32'd0);

    // Release: IDLE cycle, then RUN, head visible after the second edge.
    RST_N = 1'b1;
    #1;
    check("idle_ce", {31'd0, CE}, 32'd0);
    tick();
    check("run_valid0", {31'd0, IF_VALID}, 32'd0);
    check("run_ce", {31'd0, CE}, 32'd1);
    check("run_rden", {31'd0, READ_EN}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", {31'd0, IF_VALID}, 32'd1);
      check("stream_pc", IF_PC, 32'(4 * i));
      check("stream_instr", IF_INSTR, 32'h1000_0000 + 32'(i));
    end

    // Stall: head 0xC held, queue fills, fetch stops.
    ID_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", IF_PC, 32'h0000_000C);
      check("stall_instr", IF_INSTR, 32'h1000_0003);
      check("stall_rden", {31'd0, READ_EN}, 32'd0);
    end
    ID_READY = 1'b1;
    #1;
    check("full_pop_rden", {31'd0, READ_EN}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("resume_pc", IF_PC, 32'h10 + 32'(4 * i));
      check("resume_instr", IF_INSTR, 32'h1000_0004 + 32'(i));
    end

    // Redirect with full queue.
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0040;
    #1;
    check("redir_rden", {31'd0, READ_EN}, 32'd0);
    tick();
    REDIRECT = 1'b0;
    check("redir_flush", {31'd0, IF_VALID}, 32'd0);
    tick();
    check("redir_valid", {31'd0, IF_VALID}, 32'd1);
    check("redir_pc", IF_PC, 32'h0000_0040);
    check("redir_instr", IF_INSTR, 32'h1000_0010);
    tick();
    check("redir_pc_next", IF_PC, 32'h0000_0044);

    // Back-to-back redirects: the last target wins.
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0080;
    tick();
    REDIRECT_PC = 32'h0000_0100;
    tick();
    REDIRECT = 1'b0;
    check("b2b_flush", {31'd0, IF_VALID}, 32'd0);
    tick();
    check("b2b_pc", IF_PC, 32'h0000_0100);
    check("b2b_instr", IF_INSTR, 32'h1000_0040);

    // ROM address wrap at word 1023.
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0FF8;
    tick();
    REDIRECT = 1'b0;
    check("wrap_addr0", {22'd0, INS_ADDRESS}, 32'd1022);
    tick();
    check("wrap_addr1", {22'd0, INS_ADDRESS}, 32'd1023);
    tick();
    check("wrap_addr2", {22'd0, INS_ADDRESS}, 32'd0);
    check("wrap_pc_ffc", IF_PC, 32'h0000_0FFC);
    check("wrap_instr_ffc", IF_INSTR, 32'h1000_03FF);
    tick();
    check("wrap_pc_1000", IF_PC, 32'h0000_1000);
    check("wrap_instr_1000", IF_INSTR, 32'h1000_0000);

    // One-cycle reset mid-stream.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("mrst_valid", {31'd0, IF_VALID}, 32'd0);
    check("mrst_ce", {31'd0, CE}, 32'd0);
    tick();
    check("mrst_valid1", {31'd0, IF_VALID}, 32'd0);
    tick();
    check("mrst_pc", IF_PC, 32'h0);
    check("mrst_instr", IF_INSTR, 32'h1000_0000);

`ifdef MISALIGN_TRAP_EN
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0022;
    tick();
    REDIRECT = 1'b0;
    check("trap_flag", {31'd0, IF_MISALIGN}, 32'd1);
    check("trap_ce", {31'd0, CE}, 32'd0);
    check("trap_valid", {31'd0, IF_VALID}, 32'd0);
    tick(); tick();
    check("halt_flag", {31'd0, IF_MISALIGN}, 32'd1);
    check("halt_valid", {31'd0, IF_VALID}, 32'd0);
    check("halt_rden", {31'd0, READ_EN}, 32'd0);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0020;
    tick();
    REDIRECT = 1'b0;
    check("untrap_flag", {31'd0, IF_MISALIGN}, 32'd0);
    check("untrap_ce", {31'd0, CE}, 32'd1);
    check("untrap_valid", {31'd0, IF_VALID}, 32'd0);
    tick();
    check("untrap_pc", IF_PC, 32'h0000_0020);
    check("untrap_instr", IF_INSTR, 32'h1000_0008);
`else
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0022;
    tick();
    REDIRECT = 1'b0;
    check("align_valid", {31'd0, IF_VALID}, 32'd0);
    tick();
    check("align_pc", IF_PC, 32'h0000_0020);
    check("align_instr", IF_INSTR, 32'h1000_0008);
    check("align_flag", {31'd0, IF_MISALIGN}, 32'd0);
    tick();
    check("align_pc_next", IF_PC, 32'h0000_0024);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
